waveform_line_scheduler: RTL and testbench
==========================================

Name: waveform_line_scheduler

Overview:
Sequences the line drawer for each video frame. For every frame it reads NUM_POINTS signed audio samples from the sample buffer, maps each sample to a screen row and issues NUM_POINTS-1 connected line segments to the line drawer, one at a time. It sits between the sample buffer and the line drawer and is the only block that drives the drawer's start and coordinate inputs.

Parameters:
- SCREEN_WIDTH, 640, visible width in pixels
- SCREEN_HEIGHT, 480, visible height in pixels
- SAMPLE_WIDTH, 24, signed sample width
- NUM_POINTS, 64, samples per frame; must be at least 2
- X_STEP, 10, horizontal pixels per segment; (NUM_POINTS-1)*X_STEP must be at most SCREEN_WIDTH-1
- Y_SHIFT, 15, arithmetic right shift applied to a sample before mapping
- COORD_WIDTH, $clog2(SCREEN_WIDTH), coordinate width
- SAMPLE_ADDR_WIDTH, $clog2(NUM_POINTS), sample buffer address width

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse requesting a frame draw
- sample_rd_en  out  1  sample buffer read strobe
- sample_addr  out  SAMPLE_ADDR_WIDTH  sample buffer read address
- sample_data  in  SAMPLE_WIDTH  signed read data, valid one cycle after sample_rd_en
- line_start  out  1  drawer start
- line_x1, line_y1, line_x2, line_y2  out  COORD_WIDTH each  segment endpoints
- line_done  in  1  drawer done
- busy  out  1  high whenever the state is not IDLE
- frame_done  out  1  one-cycle pulse when the last segment has completed
- overrun  out  1  one-cycle pulse when a frame_start is dropped

Behaviour:
- Reset: asynchronous and active-low. It forces state to IDLE and clears every registered output to 0, with no clock edge needed. Reset mid-segment drops line_start immediately.
- State machine: IDLE, FETCH, CAPTURE, DRAW, RELEASE, DONE.
- IDLE:
  - On frame_start: idx<=0, sample_addr<=0, sample_rd_en<=1, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: sample_rd_en<=0; go to CAPTURE.
- CAPTURE: sample_data is valid in this state. Mapping, in signed SAMPLE_WIDTH+2 arithmetic:
  - s = sample_data >>> Y_SHIFT
  - y = SCREEN_HEIGHT/2 - s
  - if y<0 then y=0; if y>SCREEN_HEIGHT-1 then y=SCREEN_HEIGHT-1
- CAPTURE when idx==0:
  - y_prev<=y, x_prev<=0, idx<=1
  - sample_addr<=1, sample_rd_en<=1, go to FETCH
- CAPTURE when idx>0:
  - line_x1<=x_prev, line_y1<=y_prev
  - line_x2<=x_prev+X_STEP (accumulator; no multiplier), line_y2<=y
  - line_start<=1, go to DRAW
- DRAW: coordinates and line_start are held stable. When line_done=1: line_start<=0, go to RELEASE.
- RELEASE: wait for line_done=0. The drawer holds done while start is high and returns to idle only after start falls. Then:
  - x_prev<=line_x2, y_prev<=line_y2
  - if idx==NUM_POINTS-1, go to DONE
  - else idx<=idx+1, sample_addr<=idx+1, sample_rd_en<=1, go to FETCH
- DONE: frame_done<=1 for exactly one cycle; go to IDLE.
- Handshake rules:
  - line_start never rises while line_done=1.
  - Coordinates never change while line_start=1.
  - Exactly one segment is outstanding at any time.
- busy is combinational from state: busy = (state != IDLE).
- frame_start when state != IDLE: the request is ignored, overrun=1 for one cycle, and the current frame is unaffected. frame_start in the same cycle DONE returns to IDLE is also dropped and flags overrun.
- Per frame:
  - Each address 0..NUM_POINTS-1 is read exactly once, in order, with sample_rd_en high for one cycle per read.
  - NUM_POINTS-1 segments are issued.
  - Last segment x2 = (NUM_POINTS-1)*X_STEP.
- line_done high while in IDLE, FETCH or CAPTURE is ignored.

Test Plan:
1. Flat frame: NUM_POINTS=4, X_STEP=10, all samples 0, then frame_start. Required: segments (0,240)-(10,240), (10,240)-(20,240), (20,240)-(30,240) in that order; one frame_done; busy low afterwards.
2. Mapping and clamp: samples 0x7FFFFF, 0x800000, 0x008000, 0xFFFF8000. Required: y values 0 (clamped from -15), 479 (clamped from 496), 239 and 241. Segments chain, so each y1 equals the previous y2.
3. Slow drawer: line_done asserts 7 cycles after line_start and falls 3 cycles after line_start drops. Required:
   - coordinates stable throughout each DRAW
   - next line_start rises only after line_done=0
   - no segment lost or duplicated
4. frame_start pulsed during DRAW of segment 2. Required: overrun pulse in the same cycle; sample_addr sequence not restarted; exactly one frame_done.
5. resetn low mid-DRAW, asynchronous between clock edges. Required: line_start, busy and all outputs 0 immediately. After release, frame_start produces sample_addr=0 first and a complete frame.
6. Read port: capture sample_rd_en and sample_addr over a frame with NUM_POINTS=64. Required: addresses 0..63 each exactly once, ascending; rd_en one cycle per address; sample_data sampled exactly one cycle after each strobe.

Source files
------------

// File: rtl/waveform_line_scheduler_if.sv
// Sample-buffer read port, line-drawer handshake and frame control/status of the scheduler.
// master = scheduler side, slave = environment (sample buffer, drawer, frame sequencer).
interface waveform_line_scheduler_if #(
  parameter int SAMPLE_WIDTH      = 24,
  parameter int COORD_WIDTH       = 10,
  parameter int SAMPLE_ADDR_WIDTH = 6
);
  logic                         frame_start;
  logic                         sample_rd_en;
  logic [SAMPLE_ADDR_WIDTH-1:0] sample_addr;
  logic [SAMPLE_WIDTH-1:0]      sample_data;
  logic                         line_start;
  logic [COORD_WIDTH-1:0]       line_x1;
  logic [COORD_WIDTH-1:0]       line_y1;
  logic [COORD_WIDTH-1:0]       line_x2;
  logic [COORD_WIDTH-1:0]       line_y2;
  logic                         line_done;
  logic                         busy;
  logic                         frame_done;
  logic                         overrun;

  modport master (
    input  frame_start, sample_data, line_done,
    output sample_rd_en, sample_addr, line_start,
           line_x1, line_y1, line_x2, line_y2,
           busy, frame_done, overrun
  );

  modport slave (
    output frame_start, sample_data, line_done,
    input  sample_rd_en, sample_addr, line_start,
           line_x1, line_y1, line_x2, line_y2,
           busy, frame_done, overrun
  );
endinterface

// File: rtl/waveform_line_scheduler.sv
// Per-frame sequencer: fetches NUM_POINTS samples, maps each to a screen row and
// hands NUM_POINTS-1 chained segments to the line drawer one at a time.
module waveform_line_scheduler #(
  parameter int SCREEN_WIDTH      = 640,
  parameter int SCREEN_HEIGHT     = 480,
  parameter int SAMPLE_WIDTH      = 24,
  parameter int NUM_POINTS        = 64,
  parameter int X_STEP            = 10,
  parameter int Y_SHIFT           = 15,
  parameter int COORD_WIDTH       = $clog2(SCREEN_WIDTH),
  parameter int SAMPLE_ADDR_WIDTH = $clog2(NUM_POINTS)
) (
  input  logic                      clk,
  input  logic                      resetn,
  waveform_line_scheduler_if.master bus
);

  localparam int EXT_W = SAMPLE_WIDTH + 2;
  localparam logic signed [EXT_W-1:0]       HALF_H   = EXT_W'(SCREEN_HEIGHT / 2);
  localparam logic signed [EXT_W-1:0]       Y_MAX    = EXT_W'(SCREEN_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0]        Y_CLAMP  = COORD_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0]        X_INC    = COORD_WIDTH'(X_STEP);
  localparam logic [SAMPLE_ADDR_WIDTH-1:0]  LAST_IDX = SAMPLE_ADDR_WIDTH'(NUM_POINTS - 1);
  localparam logic [SAMPLE_ADDR_WIDTH-1:0]  IDX_ONE  = SAMPLE_ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DRAW    = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                       r_state, w_state_next;
  logic [SAMPLE_ADDR_WIDTH-1:0] r_idx, w_idx_next;
  logic [SAMPLE_ADDR_WIDTH-1:0] r_sample_addr, w_sample_addr_next;
  logic                         r_sample_rd_en, w_sample_rd_en_next;
  logic                         r_line_start, w_line_start_next;
  logic [COORD_WIDTH-1:0]       r_line_x1, w_line_x1_next;
  logic [COORD_WIDTH-1:0]       r_line_y1, w_line_y1_next;
  logic [COORD_WIDTH-1:0]       r_line_x2, w_line_x2_next;
  logic [COORD_WIDTH-1:0]       r_line_y2, w_line_y2_next;
  logic [COORD_WIDTH-1:0]       r_x_prev, w_x_prev_next;
  logic [COORD_WIDTH-1:0]       r_y_prev, w_y_prev_next;
  logic                         r_frame_done, w_frame_done_next;
  logic                         r_overrun, w_overrun_next;

  // Sample-to-row mapping; two guard bits keep the subtraction from wrapping.
  logic signed [EXT_W-1:0] w_sample_ext;
  logic signed [EXT_W-1:0] w_shifted;
  logic signed [EXT_W-1:0] w_y_raw;
  logic [COORD_WIDTH-1:0]  w_y;

  assign w_sample_ext = EXT_W'($signed(bus.sample_data));
  assign w_shifted    = w_sample_ext >>> Y_SHIFT;
  assign w_y_raw      = HALF_H - w_shifted;

  always_comb begin
    w_y = w_y_raw[COORD_WIDTH-1:0];
    if (w_y_raw < 0) begin
      w_y = '0;
    end else if (w_y_raw > Y_MAX) begin
      w_y = Y_CLAMP;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_sample_addr  <= '0;
      r_sample_rd_en <= 1'b0;
      r_line_start   <= 1'b0;
      r_line_x1      <= '0;
      r_line_y1      <= '0;
      r_line_x2      <= '0;
      r_line_y2      <= '0;
      r_x_prev       <= '0;
      r_y_prev       <= '0;
      r_frame_done   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_idx          <= w_idx_next;
      r_sample_addr  <= w_sample_addr_next;
      r_sample_rd_en <= w_sample_rd_en_next;
      r_line_start   <= w_line_start_next;
      r_line_x1      <= w_line_x1_next;
      r_line_y1      <= w_line_y1_next;
      r_line_x2      <= w_line_x2_next;
      r_line_y2      <= w_line_y2_next;
      r_x_prev       <= w_x_prev_next;
      r_y_prev       <= w_y_prev_next;
      r_frame_done   <= w_frame_done_next;
      r_overrun      <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_idx_next          = r_idx;
    w_sample_addr_next  = r_sample_addr;
    w_sample_rd_en_next = 1'b0;
    w_line_start_next   = r_line_start;
    w_line_x1_next      = r_line_x1;
    w_line_y1_next      = r_line_y1;
    w_line_x2_next      = r_line_x2;
    w_line_y2_next      = r_line_y2;
    w_x_prev_next       = r_x_prev;
    w_y_prev_next       = r_y_prev;
    w_frame_done_next   = 1'b0;
    // A request arriving while a frame is in flight (DONE included) is dropped.
    w_overrun_next      = bus.frame_start && (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (bus.frame_start) begin
          w_idx_next          = '0;
          w_sample_addr_next  = '0;
          w_sample_rd_en_next = 1'b1;
          w_state_next        = S_FETCH;
        end
      end

      S_FETCH: begin
        w_state_next = S_CAPTURE;
      end

      S_CAPTURE: begin
        if (r_idx == '0) begin
          w_y_prev_next       = w_y;
          w_x_prev_next       = '0;
          w_idx_next          = IDX_ONE;
          w_sample_addr_next  = IDX_ONE;
          w_sample_rd_en_next = 1'b1;
          w_state_next        = S_FETCH;
        end else begin
          w_line_x1_next    = r_x_prev;
          w_line_y1_next    = r_y_prev;
          w_line_x2_next    = r_x_prev + X_INC;
          w_line_y2_next    = w_y;
          w_line_start_next = 1'b1;
          w_state_next      = S_DRAW;
        end
      end

      S_DRAW: begin
        if (bus.line_done) begin
          w_line_start_next = 1'b0;
          w_state_next      = S_RELEASE;
        end
      end

      // The drawer keeps done high until it sees start fall; wait it out.
      S_RELEASE: begin
        if (!bus.line_done) begin
          w_x_prev_next = r_line_x2;
          w_y_prev_next = r_line_y2;
          if (r_idx == LAST_IDX) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next          = r_idx + IDX_ONE;
            w_sample_addr_next  = r_idx + IDX_ONE;
            w_sample_rd_en_next = 1'b1;
            w_state_next        = S_FETCH;
          end
        end
      end

      S_DONE: begin
        w_frame_done_next = 1'b1;
        w_state_next      = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.busy         = (r_state != S_IDLE);
  assign bus.sample_rd_en = r_sample_rd_en;
  assign bus.sample_addr  = r_sample_addr;
  assign bus.line_start   = r_line_start;
  assign bus.line_x1      = r_line_x1;
  assign bus.line_y1      = r_line_y1;
  assign bus.line_x2      = r_line_x2;
  assign bus.line_y2      = r_line_y2;
  assign bus.frame_done   = r_frame_done;
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_waveform_line_scheduler.sv
// Bench for waveform_line_scheduler: a 4-point instance driven through directed and random
// frames against a segment model, plus a 64-point instance for the read-port sequence.
module tb_waveform_line_scheduler;

  localparam int SW  = 24;
  localparam int CW  = 10;
  localparam int XS  = 10;
  localparam int NP  = 4;
  localparam int AW  = 2;
  localparam int NP2 = 64;
  localparam int AW2 = 6;
  localparam int SCR_H = 480;
  localparam int DIVISOR = 32768;

  typedef struct {
    int x1;
    int y1;
    int x2;
    int y2;
  } seg_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  waveform_line_scheduler_if #(.SAMPLE_WIDTH(SW), .COORD_WIDTH(CW), .SAMPLE_ADDR_WIDTH(AW))  bus_a ();
  waveform_line_scheduler_if #(.SAMPLE_WIDTH(SW), .COORD_WIDTH(CW), .SAMPLE_ADDR_WIDTH(AW2)) bus_b ();

  waveform_line_scheduler #(.NUM_POINTS(NP), .X_STEP(XS)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  waveform_line_scheduler #(.NUM_POINTS(NP2), .X_STEP(XS)) u_dut64 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Row model: floor(sample / 2^15) by plain division, then centre and clamp to the screen.
  function automatic int map_y(input logic [SW-1:0] s);
    int v, q, y;
    v = $signed(s);
    if (v >= 0) q = v / DIVISOR;
    else        q = -((-v + DIVISOR - 1) / DIVISOR);
    y = SCR_H / 2 - q;
    if (y < 0) y = 0;
    if (y > SCR_H - 1) y = SCR_H - 1;
    return y;
  endfunction

  function automatic logic [SW-1:0] rand_sample();
    int v;
    case ($urandom_range(0, 2))
      0:       v = int'($urandom);
      1:       v = int'($urandom_range(0, 2097152)) - 1048576;
      default: v = int'($urandom_range(0, 80000)) - 40000;
    endcase
    return SW'(v);
  endfunction

  // ---------------- environment for the 4-point instance ----------------
  logic [SW-1:0] mem_a [NP];
  logic [SW-1:0] clamp_pat [NP] = '{24'h7FFFFF, 24'h800000, 24'h008000, 24'hFF8000};
  logic [SW-1:0] sdata_a = '0;
  logic          done_a  = 1'b0;
  int            dcnt_a  = 0;
  int            d_on    = 1;
  int            d_off   = 1;

  assign bus_a.sample_data = sdata_a;
  assign bus_a.line_done   = done_a;

  // Read data is valid only the cycle after a strobe; anything else is junk.
  always @(posedge clk)
    sdata_a <= bus_a.sample_rd_en ? mem_a[bus_a.sample_addr] : SW'($urandom);

  always @(posedge clk) begin
    if (bus_a.line_start && !done_a) begin
      if (dcnt_a + 1 >= d_on) begin
        done_a <= 1'b1;
        dcnt_a <= 0;
      end else begin
        dcnt_a <= dcnt_a + 1;
      end
    end else if (!bus_a.line_start && done_a) begin
      if (dcnt_a + 1 >= d_off) begin
        done_a <= 1'b0;
        dcnt_a <= 0;
      end else begin
        dcnt_a <= dcnt_a + 1;
      end
    end else begin
      dcnt_a <= 0;
    end
  end

  seg_t          exp_q [$];
  logic          prev_start_a = 1'b0;
  logic          prev_done_a  = 1'b0;
  logic          prev_rd_a    = 1'b0;
  logic [4*CW-1:0] held_a     = '0;
  int            seg_cnt_a    = 0;
  int            rd_cnt_a     = 0;
  int            n_fd_a       = 0;
  int            n_ovr_a      = 0;

  always @(negedge clk) begin
    if (bus_a.sample_rd_en) begin
      check_eq("rd_addr", 32'(bus_a.sample_addr), rd_cnt_a % NP);
      check_eq("rd_single_cycle", 32'(prev_rd_a), 0);
    end
    rd_cnt_a <= !resetn ? 0 : rd_cnt_a + (bus_a.sample_rd_en ? 1 : 0);

    if (bus_a.line_start && !prev_start_a) begin
      check_eq("start_while_done", 32'(prev_done_a), 0);
      check_eq("busy_in_draw", 32'(bus_a.busy), 1);
      check_eq("seg_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check_eq("seg_x1", 32'(bus_a.line_x1), exp_q[0].x1);
        check_eq("seg_y1", 32'(bus_a.line_y1), exp_q[0].y1);
        check_eq("seg_x2", 32'(bus_a.line_x2), exp_q[0].x2);
        check_eq("seg_y2", 32'(bus_a.line_y2), exp_q[0].y2);
        void'(exp_q.pop_front());
      end
      $display("seg A: (%0d,%0d)-(%0d,%0d)", bus_a.line_x1, bus_a.line_y1,
               bus_a.line_x2, bus_a.line_y2);
      seg_cnt_a <= seg_cnt_a + 1;
      held_a    <= {bus_a.line_x1, bus_a.line_y1, bus_a.line_x2, bus_a.line_y2};
    end else if (bus_a.line_start) begin
      check_eq("coord_stable",
               32'({bus_a.line_x1, bus_a.line_y1, bus_a.line_x2, bus_a.line_y2} == held_a), 1);
    end

    if (bus_a.frame_done) begin
      n_fd_a <= n_fd_a + 1;
      check_eq("busy_after_done", 32'(bus_a.busy), 0);
    end
    if (bus_a.overrun) n_ovr_a <= n_ovr_a + 1;

    prev_start_a <= bus_a.line_start;
    prev_done_a  <= done_a;
    prev_rd_a    <= bus_a.sample_rd_en;
  end

  // ---------------- environment for the 64-point instance ----------------
  logic [SW-1:0] mem_b [NP2];
  logic [SW-1:0] sdata_b = '0;
  logic          done_b  = 1'b0;
  logic          prev_start_b = 1'b0;
  logic          prev_rd_b    = 1'b0;
  int            seg_cnt_b    = 0;
  int            rd_cnt_b     = 0;
  int            n_fd_b       = 0;
  int            last_x2_b    = 0;

  assign bus_b.sample_data = sdata_b;
  assign bus_b.line_done   = done_b;

  always @(posedge clk) begin
    sdata_b <= bus_b.sample_rd_en ? mem_b[bus_b.sample_addr] : SW'($urandom);
    done_b  <= bus_b.line_start;
  end

  always @(negedge clk) begin
    if (bus_b.sample_rd_en) begin
      check_eq("b_rd_addr", 32'(bus_b.sample_addr), rd_cnt_b % NP2);
      check_eq("b_rd_single_cycle", 32'(prev_rd_b), 0);
    end
    rd_cnt_b <= !resetn ? 0 : rd_cnt_b + (bus_b.sample_rd_en ? 1 : 0);

    if (bus_b.line_start && !prev_start_b) begin
      check_eq("b_seg_x1", 32'(bus_b.line_x1), XS * (seg_cnt_b % (NP2 - 1)));
      check_eq("b_seg_x2", 32'(bus_b.line_x2), XS * (seg_cnt_b % (NP2 - 1) + 1));
      check_eq("b_seg_y1", 32'(bus_b.line_y1), map_y(mem_b[seg_cnt_b % (NP2 - 1)]));
      check_eq("b_seg_y2", 32'(bus_b.line_y2), map_y(mem_b[seg_cnt_b % (NP2 - 1) + 1]));
      $display("seg B: (%0d,%0d)-(%0d,%0d)", bus_b.line_x1, bus_b.line_y1,
               bus_b.line_x2, bus_b.line_y2);
      seg_cnt_b <= seg_cnt_b + 1;
      last_x2_b <= int'(bus_b.line_x2);
    end
    if (bus_b.frame_done) n_fd_b <= n_fd_b + 1;

    prev_start_b <= bus_b.line_start;
    prev_rd_b    <= bus_b.sample_rd_en;
  end

  // inject: 0 none, 1 frame_start during segment 2, 2 async reset during segment 2
  task automatic run_frame_a(input int pattern, input int inject);
    int fd0, ovr0, rd0, seg0;
    int ys [NP];
    bit hit;
    for (int i = 0; i < NP; i++) begin
      case (pattern)
        0:       mem_a[i] = '0;
        1:       mem_a[i] = clamp_pat[i];
        default: mem_a[i] = rand_sample();
      endcase
      ys[i] = map_y(mem_a[i]);
    end
    exp_q.delete();
    for (int i = 1; i < NP; i++)
      exp_q.push_back(seg_t'{XS * (i - 1), ys[i - 1], XS * i, ys[i]});
    fd0  = n_fd_a;
    ovr0 = n_ovr_a;
    rd0  = rd_cnt_a;
    seg0 = seg_cnt_a;
    hit  = 1'b0;

    bus_a.frame_start = 1'b1;
    @(negedge clk);
    bus_a.frame_start = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      if (n_fd_a != fd0) break;
      if (inject != 0 && !hit && seg_cnt_a == seg0 + 2 && bus_a.line_start) begin
        hit = 1'b1;
        if (inject == 1) begin
          bus_a.frame_start = 1'b1;
          @(negedge clk);
          bus_a.frame_start = 1'b0;
          check_eq("overrun_pulse", 32'(bus_a.overrun), 1);
          check_eq("busy_at_overrun", 32'(bus_a.busy), 1);
        end else begin
          #2 resetn = 1'b0;
          #1;
          check_eq("rst_line_start", 32'(bus_a.line_start), 0);
          check_eq("rst_busy", 32'(bus_a.busy), 0);
          check_eq("rst_rd_en", 32'(bus_a.sample_rd_en), 0);
          check_eq("rst_addr", 32'(bus_a.sample_addr), 0);
          check_eq("rst_x1", 32'(bus_a.line_x1), 0);
          check_eq("rst_y1", 32'(bus_a.line_y1), 0);
          check_eq("rst_x2", 32'(bus_a.line_x2), 0);
          check_eq("rst_y2", 32'(bus_a.line_y2), 0);
          check_eq("rst_frame_done", 32'(bus_a.frame_done), 0);
          check_eq("rst_overrun", 32'(bus_a.overrun), 0);
          @(negedge clk);
          #2 resetn = 1'b1;
          break;
        end
      end else begin
        @(negedge clk);
      end
    end

    if (inject == 2) begin
      check_eq("rst_injected", 32'(hit), 1);
      exp_q.delete();
      repeat (10) @(negedge clk);
      check_eq("rst_no_frame_done", n_fd_a - fd0, 0);
      check_eq("rst_idle", 32'(bus_a.busy), 0);
    end else begin
      repeat (3) @(negedge clk);
      if (inject == 1) check_eq("overrun_injected", 32'(hit), 1);
      check_eq("frame_done_count", n_fd_a - fd0, 1);
      check_eq("segments_left", exp_q.size(), 0);
      check_eq("segments_issued", seg_cnt_a - seg0, NP - 1);
      check_eq("reads_issued", rd_cnt_a - rd0, NP);
      check_eq("overrun_count", n_ovr_a - ovr0, (inject == 1) ? 1 : 0);
      check_eq("busy_idle", 32'(bus_a.busy), 0);
    end
  endtask

  task automatic run_frame_b();
    int fd0, rd0, seg0;
    for (int i = 0; i < NP2; i++) mem_b[i] = rand_sample();
    fd0  = n_fd_b;
    rd0  = rd_cnt_b;
    seg0 = seg_cnt_b;
    bus_b.frame_start = 1'b1;
    @(negedge clk);
    bus_b.frame_start = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (n_fd_b != fd0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check_eq("b_frame_done_count", n_fd_b - fd0, 1);
    check_eq("b_reads_issued", rd_cnt_b - rd0, NP2);
    check_eq("b_segments_issued", seg_cnt_b - seg0, NP2 - 1);
    check_eq("b_last_x2", last_x2_b, XS * (NP2 - 1));
    check_eq("b_busy_idle", 32'(bus_b.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.frame_start = 1'b0;
    bus_b.frame_start = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check_eq("reset_busy", 32'(bus_a.busy), 0);
    check_eq("reset_line_start", 32'(bus_a.line_start), 0);
    check_eq("reset_rd_en", 32'(bus_a.sample_rd_en), 0);
    check_eq("reset_frame_done", 32'(bus_a.frame_done), 0);
    check_eq("reset_overrun", 32'(bus_a.overrun), 0);
    check_eq("reset_busy_b", 32'(bus_b.busy), 0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    d_on = 1; d_off = 1;
    run_frame_a(0, 0);
    run_frame_a(1, 0);

    d_on = 7; d_off = 3;
    run_frame_a(2, 0);
    run_frame_a(1, 0);

    d_on = 1; d_off = 1;
    run_frame_a(2, 1);
    run_frame_a(2, 2);
    run_frame_a(0, 0);

    for (int f = 0; f < 8; f++) begin
      d_on  = int'($urandom_range(1, 6));
      d_off = int'($urandom_range(1, 4));
      run_frame_a(2, (f == 5) ? 1 : 0);
    end

    run_frame_b();
    run_frame_b();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
